operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader_pkg.sv | 6 +
 rtl/operand_par_chk.sv | 11 +
 rtl/operand_loader.sv | 94 +++++++++
 tb/tb_operand_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared FSM state type and default sizes for operand_loader
package operand_loader_pkg;
  typedef enum logic [1:0] {S_A, S_B, S_C} state_t;
  localparam int DEF_WIDTH = 12;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/operand_par_chk.sv
// operand_par_chk: flags a word whose data bits plus parity bit have even parity
// Ports: i_data word, i_par parity bit, o_ok high when parity is even.
module operand_par_chk #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_par,
  output logic             o_ok
);
  assign o_ok = ~^{i_data, i_par};
endmodule

// File: rtl/operand_loader.sv
// operand_loader: gathers three accepted words into a registered a/b/c triple with a one-cycle en pulse
// Ports: clk; rst async active-low; in_valid/in_ready/in_data upstream handshake; hold backpressure;
//   clr flushes a partial triple; a/b/c triple, en new-triple pulse, tri_cnt wrapping triple count.
// OPERAND_PARITY_EN adds in_par/par_err; words with odd parity are accepted, dropped and restart the triple.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             hold,
  input  logic             clr,
`ifdef OPERAND_PARITY_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             en,
  output logic [CNT_W-1:0] tri_cnt
);
  state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sa, r_sb, r_a, r_b, r_c;
  logic r_en;
  logic [CNT_W-1:0] r_cnt;
  logic w_acc, w_ok, w_ld_a, w_ld_b, w_fire;
  assign in_ready = rst && !hold && !clr;
  assign w_acc = in_valid && in_ready;
`ifdef OPERAND_PARITY_EN
  logic r_par_err;
  operand_par_chk #(.WIDTH(WIDTH)) u_par_chk (
    .i_data(in_data),
    .i_par (in_par),
    .o_ok  (w_ok)
  );
  assign par_err = r_par_err;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_par_err <= 1'b0;
    else if (clr) r_par_err <= 1'b0;
    else if (w_acc && !w_ok) r_par_err <= 1'b1;
`else
  assign w_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_A;
    else r_state <= w_state_nxt;
  always_comb
    w_state_nxt = clr ? S_A :
                  !w_acc ? r_state :
                  !w_ok ? S_A :
                  r_state == S_A ? S_B :
                  r_state == S_B ? S_C : S_A;
  always_comb begin
    w_ld_a = w_acc && w_ok && r_state == S_A;
    w_ld_b = w_acc && w_ok && r_state == S_B;
    w_fire = w_acc && w_ok && r_state == S_C;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_en  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (clr) begin
        r_sa <= '0;
        r_sb <= '0;
      end else begin
        if (w_ld_a) r_sa <= in_data;
        if (w_ld_b) r_sb <= in_data;
      end
      r_en <= w_fire;
      if (w_fire) begin
        r_a   <= r_sa;
        r_b   <= r_sb;
        r_c   <= in_data;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  assign a = r_a;
  assign b = r_b;
  assign c = r_c;
  assign en = r_en;
  assign tri_cnt = r_cnt;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: randomized and directed self-checking bench for operand_loader
module tb_operand_loader;
  localparam int W = 12;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic hold = 1'b0;
  logic clr = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, en;
  logic [W-1:0] a, b, c;
  logic [CW-1:0] tri_cnt;
`ifdef OPERAND_PARITY_EN
  logic in_par = 1'b0;
  logic par_err;
`endif
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_w[3];
  int m_n = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_c = '0;
  logic m_en = 1'b0;
  int m_cnt = 0;
  logic m_perr = 1'b0;
  int pulses = 0;
  bit pe;
  operand_loader dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .hold(hold),
    .clr(clr),
`ifdef OPERAND_PARITY_EN
    .in_par(in_par),
    .par_err(par_err),
`endif
    .a(a),
    .b(b),
    .c(c),
    .en(en),
    .tri_cnt(tri_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input bit v, input logic [W-1:0] d, input bit h, input bit cl, input bit bp = 1'b0);
    in_valid = v;
    in_data = d;
    hold = h;
    clr = cl;
`ifdef OPERAND_PARITY_EN
    in_par = (^d) ^ bp;
`endif
    @(posedge clk);
    #1;
  endtask
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_n = 0;
        m_a = '0;
        m_b = '0;
        m_c = '0;
        m_en = 1'b0;
        m_cnt = 0;
        m_perr = 1'b0;
      end else begin
        m_en = 1'b0;
        pe = 1'b0;
`ifdef OPERAND_PARITY_EN
        pe = (^in_data) ^ in_par;
`endif
        if (clr) begin
          m_n = 0;
          m_perr = 1'b0;
        end else if (in_valid && !hold) begin
          if (pe) begin
            m_n = 0;
            m_perr = 1'b1;
          end else begin
            m_w[m_n] = in_data;
            m_n++;
            if (m_n == 3) begin
              m_a = m_w[0];
              m_b = m_w[1];
              m_c = m_w[2];
              m_en = 1'b1;
              m_cnt = (m_cnt + 1) % 256;
              m_n = 0;
              pulses++;
            end
          end
        end
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      chk("a", a, m_a);
      chk("b", b, m_b);
      chk("c", c, m_c);
      chk("en", en, m_en);
      chk("tri_cnt", tri_cnt, m_cnt);
      chk("in_ready", in_ready, rst && !hold && !clr);
`ifdef OPERAND_PARITY_EN
      chk("par_err", par_err, m_perr);
`endif
    end
  end
  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", a, 0);
    chk("rst_en", en, 0);
    chk("rst_cnt", tri_cnt, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b1;
    drive(1, 12'h123, 0, 0);
    drive(1, 12'h456, 0, 0);
    chk("basic_a_unchanged", a, 0);
    drive(1, 12'h789, 0, 0);
    chk("basic_a", a, 12'h123);
    chk("basic_b", b, 12'h456);
    chk("basic_c", c, 12'h789);
    chk("basic_en", en, 1);
    chk("basic_cnt", tri_cnt, 1);
    drive(0, 0, 0, 0);
    chk("basic_en_low", en, 0);
    p0 = pulses;
    for (int i = 1; i <= 9; i++) drive(1, W'(i), 0, 0);
    chk("stream_pulses", pulses - p0, 3);
    chk("stream_a", a, 7);
    chk("stream_c", c, 9);
    chk("stream_cnt", tri_cnt, 4);
    drive(1, 12'h0A1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 12'h0FF, 1, 0);
      chk("hold_ready", in_ready, 0);
    end
    drive(1, 12'h0B2, 0, 0);
    drive(1, 12'h0C3, 0, 0);
    chk("hold_a", a, 12'h0A1);
    chk("hold_b", b, 12'h0B2);
    chk("hold_c", c, 12'h0C3);
    chk("hold_cnt", tri_cnt, 5);
    drive(1, 12'hAAA, 0, 0);
    drive(1, 12'hBBB, 0, 0);
    drive(1, 12'hDDD, 0, 1);
    chk("clr_a_kept", a, 12'h0A1);
    drive(1, 12'h111, 0, 0);
    drive(1, 12'h222, 0, 0);
    chk("clr_c_kept", c, 12'h0C3);
    drive(1, 12'h333, 0, 0);
    chk("clr_a", a, 12'h111);
    chk("clr_b", b, 12'h222);
    chk("clr_c", c, 12'h333);
    chk("clr_cnt", tri_cnt, 6);
    drive(1, 12'h555, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst_a", a, 0);
    chk("midrst_cnt", tri_cnt, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    drive(1, 12'h321, 0, 0);
    drive(1, 12'h654, 0, 0);
    drive(1, 12'h987, 0, 0);
    chk("midrst_tri_a", a, 12'h321);
    chk("midrst_tri_c", c, 12'h987);
    chk("midrst_tri_cnt", tri_cnt, 1);
    for (int i = 0; i < 255 * 3; i++) drive(1, W'($urandom), 0, 0);
    chk("wrap_cnt", tri_cnt, 0);
    chk("wrap_en", en, 1);
`ifdef OPERAND_PARITY_EN
    drive(1, 12'h0AB, 0, 0);
    drive(1, 12'h001, 0, 0, 1);
    chk("par_in_par", in_par, 0);
    chk("par_err_set", par_err, 1);
    chk("par_no_en", en, 0);
    drive(1, 12'h00C, 0, 0);
    drive(1, 12'h00D, 0, 0);
    drive(1, 12'h00E, 0, 0);
    chk("par_en", en, 1);
    chk("par_a", a, 12'h00C);
    chk("par_err_sticky", par_err, 1);
    drive(0, 0, 0, 1);
    chk("par_err_clr", par_err, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        rst = 1'b0;
        drive(0, 0, 0, 0);
        rst = 1'b1;
      end
      drive($urandom_range(3) != 0, W'($urandom), $urandom_range(6) == 0,
            $urandom_range(19) == 0, $urandom_range(19) == 0);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
